// File: rtl/tx_short_preamble_gen.sv
// ---------------------------------------------------------------------------
// tx_short_preamble_gen
//
// Purpose:
//   Transmit-side source of the OFDM short training preamble. It plays
//   NUM_REP back-to-back copies of the 16-sample 802.11a short symbol as
//   complex samples on a valid/ready stream. After the final sample has been
//   accepted, it raises a one-cycle done pulse.
//
// Parameters:
//   OUT_W    output sample width (signed); table value scaled by 2^(OUT_W-8)
//   SYM_LEN  samples per short symbol (the table length, 16)
//   NUM_REP  short-symbol repetitions per preamble (1..15)
//
// Ports:
//   Clk           clock, everything on the rising edge
//   Rst_n         synchronous reset, active low
//   Start         request one preamble; only honoured while idle
//   Abort         synchronous abort, wins over Start
//   OutputReady   downstream accepts a sample when OutputEnable is also high
//   Busy          high while the preamble is running
//   OutputEnable  sample valid
//   PreambleRe    real part of the current sample
//   PreambleIm    imaginary part of the current sample
//   SampleIndex   position 0..15 inside the current short symbol
//   LastSample    high together with the final sample of the preamble
//   PreambleDone  one-cycle pulse after the final sample is accepted
// ---------------------------------------------------------------------------
module tx_short_preamble_gen #(
  parameter int OUT_W   = 8,
  parameter int SYM_LEN = 16,
  parameter int NUM_REP = 10
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic             Abort,
  input  logic             OutputReady,
  output logic             Busy,
  output logic             OutputEnable,
  output logic [OUT_W-1:0] PreambleRe,
  output logic [OUT_W-1:0] PreambleIm,
  output logic [3:0]       SampleIndex,
  output logic             LastSample,
  output logic             PreambleDone
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] LAST_IDX = 4'(SYM_LEN - 1);
  localparam logic [3:0] LAST_REP = 4'(NUM_REP - 1);

  // Real part of the short symbol at 8-bit scale (LSB = 2^-8).
  function automatic logic signed [7:0] short_sym(input logic [3:0] k);
    logic signed [7:0] v;
    case (k)
      4'd0:    v =  8'sd12;
      4'd1:    v = -8'sd34;
      4'd2:    v = -8'sd3;
      4'd3:    v =  8'sd37;
      4'd4:    v =  8'sd24;
      4'd5:    v =  8'sd37;
      4'd6:    v = -8'sd3;
      4'd7:    v = -8'sd34;
      4'd8:    v =  8'sd12;
      4'd9:    v =  8'sd1;
      4'd10:   v = -8'sd20;
      4'd11:   v = -8'sd3;
      4'd12:   v =  8'sd0;
      4'd13:   v = -8'sd3;
      4'd14:   v = -8'sd20;
      4'd15:   v =  8'sd1;
      default: v =  8'sd0;
    endcase
    return v;
  endfunction

  // Sign-extend to OUT_W, then shift left. There is no rounding and no saturation.
  function automatic logic [OUT_W-1:0] scale(input logic signed [7:0] v);
    logic signed [OUT_W-1:0] w;
    w = OUT_W'(v);
    return w <<< (OUT_W - 8);
  endfunction

  logic [1:0]       state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [3:0]       rep_q, rep_d;
  logic             oe_q, oe_d;
  logic             busy_q, busy_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic [OUT_W-1:0] re_q, re_d;
  logic [OUT_W-1:0] im_q, im_d;

  // Next-state, counter and registered-output computation
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    case (state_q)
      ST_IDLE: begin
        if (Start && !Abort) begin
          state_d = ST_RUN;
          idx_d   = 4'd0;
          rep_d   = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (Abort) begin
          state_d = ST_IDLE;
          idx_d   = 4'd0;
          rep_d   = 4'd0;
        end else if (!oe_q) begin
          // First RUN cycle. Sample 0 becomes valid on the next cycle.
          idx_d = 4'd0;
          rep_d = 4'd0;
        end else if (OutputReady) begin
          if (idx_q == LAST_IDX) begin
            idx_d = 4'd0;
            if (rep_q == LAST_REP) begin
              state_d = ST_DONE;
              rep_d   = 4'd0;
            end else begin
              rep_d = rep_q + 4'd1;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          // A stall holds the current sample unchanged.
          idx_d = idx_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        idx_d   = 4'd0;
        rep_d   = 4'd0;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 4'd0;
        rep_d   = 4'd0;
      end
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
    // Valid only after the launch cycle, so the stream starts one cycle
    // after RUN is entered.
    oe_d   = (state_d == ST_RUN) && (state_q == ST_RUN);

    if (oe_d) begin
      re_d   = scale(short_sym(idx_d));
      // The imaginary sequence is the real sequence rotated by half a symbol.
      im_d   = scale(short_sym(idx_d + 4'd8));
      last_d = (idx_d == LAST_IDX) && (rep_d == LAST_REP);
    end else begin
      re_d   = '0;
      im_d   = '0;
      last_d = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      rep_q   <= 4'd0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      done_q  <= done_d;
      re_q    <= re_d;
      im_q    <= im_d;
    end
  end

  assign Busy         = busy_q;
  assign OutputEnable = oe_q;
  assign PreambleRe   = re_q;
  assign PreambleIm   = im_q;
  assign SampleIndex  = idx_q;
  assign LastSample   = last_q;
  assign PreambleDone = done_q;

endmodule

// File: tb/tb_tx_short_preamble_gen.sv
module tb_tx_short_preamble_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference short symbol (8-bit scale)
  int RE_T[16] = '{12, -34, -3, 37, 24, 37, -3, -34, 12, 1, -20, -3, 0, -3, -20, 1};
  int IM_T[16] = '{12, 1, -20, -3, 0, -3, -20, 1, 12, -34, -3, 37, 24, 37, -3, -34};

  // DUT A: default parameters (OUT_W=8, NUM_REP=10)
  logic       rst_a = 1'b0, start_a = 1'b0, abort_a = 1'b0, ready_a = 1'b0;
  logic       busy_a, oe_a, last_a, done_a;
  logic [7:0] re_a, im_a;
  logic [3:0] idx_a;

  tx_short_preamble_gen dut_a (
    .Clk(clk), .Rst_n(rst_a), .Start(start_a), .Abort(abort_a), .OutputReady(ready_a),
    .Busy(busy_a), .OutputEnable(oe_a), .PreambleRe(re_a), .PreambleIm(im_a),
    .SampleIndex(idx_a), .LastSample(last_a), .PreambleDone(done_a)
  );

  // DUT B: NUM_REP=2, OUT_W=12
  logic        rst_b = 1'b0, start_b = 1'b0, abort_b = 1'b0, ready_b = 1'b0;
  logic        busy_b, oe_b, last_b, done_b;
  logic [11:0] re_b, im_b;
  logic [3:0]  idx_b;

  tx_short_preamble_gen #(.OUT_W(12), .SYM_LEN(16), .NUM_REP(2)) dut_b (
    .Clk(clk), .Rst_n(rst_b), .Start(start_b), .Abort(abort_b), .OutputReady(ready_b),
    .Busy(busy_b), .OutputEnable(oe_b), .PreambleRe(re_b), .PreambleIm(im_b),
    .SampleIndex(idx_b), .LastSample(last_b), .PreambleDone(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one preamble on DUT A against the reference sequence.
  // abort_at / rst_at / start_at: accept count at which to act (-1 = never).
  task automatic run_a(input string tn, input bit rnd, input int abort_at,
                       input int rst_at, input int start_at, input bit start_in_done);
    int acc = 0;
    int vcnt = 0;
    bit stalled = 1'b0;
    bit finished = 1'b0;
    bit ab, rs;
    logic [7:0] h_re = 8'd0, h_im = 8'd0;
    logic [3:0] h_idx = 4'd0;
    logic h_last = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk({tn, "_launch_oe"}, 32'(oe_a), 32'd0);
    chk({tn, "_launch_busy"}, 32'(busy_a), 32'd1);
    tick();
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      if (oe_a) begin
        vcnt++;
        if (stalled) begin
          chk({tn, "_stall_re"}, 32'(re_a), 32'(h_re));
          chk({tn, "_stall_im"}, 32'(im_a), 32'(h_im));
          chk({tn, "_stall_idx"}, 32'(idx_a), 32'(h_idx));
          chk({tn, "_stall_last"}, 32'(last_a), 32'(h_last));
        end
        chk({tn, "_re"}, 32'($signed(re_a)), RE_T[acc % 16]);
        chk({tn, "_im"}, 32'($signed(im_a)), IM_T[acc % 16]);
        chk({tn, "_idx"}, 32'(idx_a), 32'(acc % 16));
        chk({tn, "_last"}, 32'(last_a), 32'(acc == 159));
        chk({tn, "_busy"}, 32'(busy_a), 32'd1);
        h_re = re_a; h_im = im_a; h_idx = idx_a; h_last = last_a;
        ready_a = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        ab = (acc == abort_at);
        rs = (acc == rst_at);
        abort_a = ab;
        rst_a   = !rs;
        start_a = (acc == start_at);
        tick();
        abort_a = 1'b0;
        rst_a   = 1'b1;
        start_a = 1'b0;
        if (ab || rs) begin
          chk({tn, "_halt_oe"}, 32'(oe_a), 32'd0);
          chk({tn, "_halt_busy"}, 32'(busy_a), 32'd0);
          chk({tn, "_halt_done"}, 32'(done_a), 32'd0);
          chk({tn, "_halt_re"}, 32'(re_a), 32'd0);
          chk({tn, "_halt_im"}, 32'(im_a), 32'd0);
          chk({tn, "_halt_idx"}, 32'(idx_a), 32'd0);
          chk({tn, "_halt_last"}, 32'(last_a), 32'd0);
          if (rs) begin
            start_a = 1'b1;
            abort_a = 1'b1;
            tick();
            start_a = 1'b0;
            abort_a = 1'b0;
            chk({tn, "_sa_busy"}, 32'(busy_a), 32'd0);
            chk({tn, "_sa_oe"}, 32'(oe_a), 32'd0);
          end
          finished = 1'b1;
        end else if (ready_a) begin
          acc++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
        end
      end else begin
        chk({tn, "_done_pulse"}, 32'(done_a), 32'd1);
        chk({tn, "_accepts"}, 32'(acc), 32'd160);
        chk({tn, "_done_busy"}, 32'(busy_a), 32'd0);
        if (!rnd) chk({tn, "_consecutive"}, 32'(vcnt), 32'd160);
        start_a = start_in_done;
        tick();
        start_a = 1'b0;
        chk({tn, "_post_done"}, 32'(done_a), 32'd0);
        chk({tn, "_post_busy"}, 32'(busy_a), 32'd0);
        chk({tn, "_post_oe"}, 32'(oe_a), 32'd0);
        finished = 1'b1;
      end
    end
    if (!finished) chk({tn, "_timeout"}, 32'(acc), 32'd160);
  endtask

  initial begin
    // Reset both instances
    tick(); tick();
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_oe", 32'(oe_a), 32'd0);
    chk("rst_re", 32'(re_a), 32'd0);
    chk("rst_im", 32'(im_a), 32'd0);
    chk("rst_idx", 32'(idx_a), 32'd0);
    chk("rst_last", 32'(last_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_b_oe", 32'(oe_b), 32'd0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick();
    chk("idle_busy", 32'(busy_a), 32'd0);

    // 1: full-rate preamble
    run_a("t1", 1'b0, -1, -1, -1, 1'b0);
    // 2: random backpressure
    run_a("t2", 1'b1, -1, -1, -1, 1'b0);
    // 3: abort at accepted sample 40, then a clean restart
    run_a("t3", 1'b1, 40, -1, -1, 1'b0);
    run_a("t3r", 1'b0, -1, -1, -1, 1'b0);
    // 4: Start re-pulsed mid-run and in the DONE cycle, then a fresh Start
    run_a("t4", 1'b0, -1, -1, 20, 1'b1);
    run_a("t4r", 1'b1, -1, -1, -1, 1'b0);
    // 5: reset at sample 77, then Start+Abort together
    run_a("t5", 1'b0, -1, 77, -1, 1'b0);
    run_a("t5r", 1'b0, -1, -1, -1, 1'b0);

    // 6: NUM_REP=2, OUT_W=12 (sample1 Re = -34*16 = -544)
    ready_b = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("t6_launch_busy", 32'(busy_b), 32'd1);
    tick();
    for (int n = 0; n < 32; n++) begin
      chk("t6_oe", 32'(oe_b), 32'd1);
      chk("t6_re", 32'($signed(re_b)), RE_T[n % 16] * 16);
      chk("t6_im", 32'($signed(im_b)), IM_T[n % 16] * 16);
      chk("t6_idx", 32'(idx_b), 32'(n % 16));
      chk("t6_last", 32'(last_b), 32'(n == 31));
      tick();
    end
    chk("t6_done", 32'(done_b), 32'd1);
    chk("t6_done_oe", 32'(oe_b), 32'd0);
    tick();
    chk("t6_idle_busy", 32'(busy_b), 32'd0);
    chk("t6_idle_done", 32'(done_b), 32'd0);
    chk("t6_abort_idle", 32'(abort_b), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
